imm_decode_pipe: RTL and testbench

- Registered, flow-controlled immediate decode stage for the ID pipeline.
- Generalises the combinational immediate generator:
  - XLEN-parametrised (32/64) sign extension.
  - Adds shift-amount and CSR zimm formats.
  - Emits a format code alongside the immediate.
  - Carries a sideband tag (PC/ROB id) through a 2-entry skid buffer with valid/ready and flush.
- Sits between fetch/issue and the register-read/execute boundary.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/imm_decode_pipe_if.sv | 32 +++
 rtl/imm_decode_pipe_core.sv | 72 +++++++
 rtl/imm_decode_pipe.sv | 112 +++++++++++
 tb/tb_imm_decode_pipe.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | riscv_pkg                                                             |
// | Shared RISC-V decode types: datapath width, opcodes, immediate kinds. |
// | Revision: 1.1                                                         |
// +-----------------------------------------------------------------------+
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'h03,
      OP_I_TYPE = 7'h13,
      OP_AUIPC  = 7'h17,
      OP_STORE  = 7'h23,
      OP_LUI    = 7'h37,
      OP_BRANCH = 7'h63,
      OP_JALR   = 7'h67,
      OP_JAL    = 7'h6F,
      OP_SYSTEM = 7'h73
   } opcode_t;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_J     = 3'd4,
      FMT_U     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_Z     = 3'd7
   } imm_fmt_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode_pipe_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imm_decode_pipe_if                                                    |
// | Valid/ready instruction-in, immediate-out bundle for the decode stage.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface imm_decode_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_instr;
   logic [TAG_W-1:0]      in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       out_imm;
   riscv_pkg::imm_fmt_t   out_fmt;
   logic [31:0]           out_instr;
   logic [TAG_W-1:0]      out_tag;

   modport master (
      output in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_instr, out_tag
   );

   modport slave (
      input  in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_instr, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/imm_decode_pipe_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imm_decode_core                                                       |
// | Combinational immediate extraction and format classification.         |
// | Revision: 1.1                                                         |
// +-----------------------------------------------------------------------+
module imm_decode_core #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [31:0]          instr,
   output logic [XLEN-1:0]      imm,
   output riscv_pkg::imm_fmt_t  fmt
);
   import riscv_pkg::*;

   localparam int SHW = (XLEN == 64) ? 6 : 5;

   opcode_t     w_opcode;
   logic [2:0]  w_funct3;

   assign w_opcode = opcode_t'(instr[6:0]);
   assign w_funct3 = instr[14:12];

   // Signed size casts perform the sign extension to XLEN.
   always_comb begin
      imm = '0;
      fmt = FMT_NONE;
      case (w_opcode)
         OP_I_TYPE: begin
            if (w_funct3[1:0] == 2'b01) begin
               imm = XLEN'(instr[20 +: SHW]);
               fmt = FMT_SHAMT;
            end else begin
               imm = XLEN'(signed'(instr[31:20]));
               fmt = FMT_I;
            end
         end
         OP_LOAD, OP_JALR: begin
            imm = XLEN'(signed'(instr[31:20]));
            fmt = FMT_I;
         end
         OP_STORE: begin
            imm = XLEN'(signed'({instr[31:25], instr[11:7]}));
            fmt = FMT_S;
         end
         OP_BRANCH: begin
            imm = XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            fmt = FMT_B;
         end
         OP_JAL: begin
            imm = XLEN'(signed'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            fmt = FMT_J;
         end
         OP_LUI, OP_AUIPC: begin
            imm = XLEN'(signed'({instr[31:12], 12'b0}));
            fmt = FMT_U;
         end
         OP_SYSTEM: begin
            if (w_funct3[2]) begin
               imm = XLEN'(instr[19:15]);
               fmt = FMT_Z;
            end
         end
         default: begin
            imm = '0;
            fmt = FMT_NONE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/imm_decode_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imm_decode_pipe                                                       |
// | Registered immediate decode stage with 2-entry skid buffer and flush. |
// | Revision: 1.1                                                         |
// +-----------------------------------------------------------------------+
module imm_decode_pipe #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int TAG_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   imm_decode_pipe_if.slave  bus
);
   import riscv_pkg::*;

   logic [XLEN-1:0]   w_dec_imm;
   imm_fmt_t          w_dec_fmt;

   logic              r_out_valid;
   logic              r_skid_valid;
   logic              r_in_ready;
   logic [XLEN-1:0]   r_out_imm;
   imm_fmt_t          r_out_fmt;
   logic [31:0]       r_out_instr;
   logic [TAG_W-1:0]  r_out_tag;
   logic [XLEN-1:0]   r_skid_imm;
   imm_fmt_t          r_skid_fmt;
   logic [31:0]       r_skid_instr;
   logic [TAG_W-1:0]  r_skid_tag;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_out_from_skid;
   logic              w_out_from_in;
   logic              w_load_skid;
   logic              w_out_valid_nxt;
   logic              w_skid_valid_nxt;

   imm_decode_core #(.XLEN(XLEN)) u_core (
      .instr (bus.in_instr),
      .imm   (w_dec_imm),
      .fmt   (w_dec_fmt)
   );

   assign w_in_fire  = bus.in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & bus.out_ready;

   // Skid only fills while the output is held, so in_ready is low whenever it is occupied.
   assign w_out_from_skid  = w_out_fire & r_skid_valid;
   assign w_out_from_in    = w_in_fire & (~r_out_valid | w_out_fire);
   assign w_load_skid      = w_in_fire & r_out_valid & ~bus.out_ready;
   assign w_out_valid_nxt  = ~flush & (r_skid_valid | w_in_fire | (r_out_valid & ~bus.out_ready));
   assign w_skid_valid_nxt = ~flush & (r_skid_valid ? ~w_out_fire : w_load_skid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_out_valid  <= w_out_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= ~w_skid_valid_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_imm   <= '0;
         r_out_fmt   <= FMT_NONE;
         r_out_instr <= '0;
         r_out_tag   <= '0;
      end else if (!flush) begin
         if (w_out_from_skid) begin
            r_out_imm   <= r_skid_imm;
            r_out_fmt   <= r_skid_fmt;
            r_out_instr <= r_skid_instr;
            r_out_tag   <= r_skid_tag;
         end else if (w_out_from_in) begin
            r_out_imm   <= w_dec_imm;
            r_out_fmt   <= w_dec_fmt;
            r_out_instr <= bus.in_instr;
            r_out_tag   <= bus.in_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_skid_imm   <= '0;
         r_skid_fmt   <= FMT_NONE;
         r_skid_instr <= '0;
         r_skid_tag   <= '0;
      end else if (!flush && w_load_skid) begin
         r_skid_imm   <= w_dec_imm;
         r_skid_fmt   <= w_dec_fmt;
         r_skid_instr <= bus.in_instr;
         r_skid_tag   <= bus.in_tag;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_imm   = r_out_imm;
   assign bus.out_fmt   = r_out_fmt;
   assign bus.out_instr = r_out_instr;
   assign bus.out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_imm_decode_pipe                                                    |
// | Scoreboard bench: 32-bit and 64-bit instances of imm_decode_pipe.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_imm_decode_pipe;

   logic clk = 1'b0;
   logic rst;
   logic flush32;
   logic flush64;

   always #5 clk = ~clk;

   imm_decode_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
   imm_decode_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

   imm_decode_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush32),
      .bus   (b32)
   );

   imm_decode_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush64),
      .bus   (b64)
   );

   typedef struct packed {
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic [31:0] instr;
      logic [31:0] tag;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   exp_t e32;
   exp_t e64;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h37, 7'h63,
                            7'h67, 7'h6F, 7'h73, 7'h33, 7'h0F};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference decode, built at 64 bits and trimmed for the 32-bit instance.
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] tg, input bit is64);
      exp_t r;
      r.imm   = 64'd0;
      r.fmt   = 3'd0;
      r.instr = i;
      r.tag   = tg;
      case (i[6:0])
         7'h13: begin
            if (i[13:12] == 2'b01) begin
               r.imm = is64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
               r.fmt = 3'd6;
            end else begin
               r.imm = {{52{i[31]}}, i[31:20]};
               r.fmt = 3'd1;
            end
         end
         7'h03, 7'h67: begin r.imm = {{52{i[31]}}, i[31:20]}; r.fmt = 3'd1; end
         7'h23: begin r.imm = {{52{i[31]}}, i[31:25], i[11:7]}; r.fmt = 3'd2; end
         7'h63: begin r.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; r.fmt = 3'd3; end
         7'h6F: begin r.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; r.fmt = 3'd4; end
         7'h37, 7'h17: begin r.imm = {{32{i[31]}}, i[31:12], 12'd0}; r.fmt = 3'd5; end
         7'h73: if (i[14]) begin r.imm = {59'd0, i[19:15]}; r.fmt = 3'd7; end
         default: ;
      endcase
      if (!is64) r.imm[63:32] = 32'd0;
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) chk("sb32_underflow", 64'(q32.size()), 64'd1);
            else begin
               e32 = q32.pop_front();
               chk("sb32_imm", 64'(b32.out_imm), e32.imm);
               chk("sb32_fmt", 64'(b32.out_fmt), 64'(e32.fmt));
               chk("sb32_instr", 64'(b32.out_instr), 64'(e32.instr));
               chk("sb32_tag", 64'(b32.out_tag), 64'(e32.tag));
            end
         end
         if (flush32) q32.delete();
         else if (b32.in_valid && b32.in_ready) q32.push_back(model(b32.in_instr, b32.in_tag, 1'b0));
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) chk("sb64_underflow", 64'(q64.size()), 64'd1);
            else begin
               e64 = q64.pop_front();
               chk("sb64_imm", b64.out_imm, e64.imm);
               chk("sb64_fmt", 64'(b64.out_fmt), 64'(e64.fmt));
               chk("sb64_instr", 64'(b64.out_instr), 64'(e64.instr));
               chk("sb64_tag", 64'(b64.out_tag), 64'(e64.tag));
            end
         end
         if (flush64) q64.delete();
         else if (b64.in_valid && b64.in_ready) q64.push_back(model(b64.in_instr, b64.in_tag, 1'b1));
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Call aligned just after a rising edge; returns just after the accepting edge with in_valid still high.
   task automatic send(input bit s64, input logic [31:0] ins, input logic [31:0] tg);
      int n;
      n = 0;
      if (s64) begin b64.in_valid = 1'b1; b64.in_instr = ins; b64.in_tag = tg; end
      else     begin b32.in_valid = 1'b1; b32.in_instr = ins; b32.in_tag = tg; end
      do begin
         @(negedge clk);
         n++;
      end while (!(s64 ? b64.in_ready : b32.in_ready) && n < 50);
      if (!(s64 ? b64.in_ready : b32.in_ready))
         chk("send_timeout", 64'(s64 ? b64.in_ready : b32.in_ready), 64'd1);
      sync();
   endtask

   task automatic stop(input bit s64);
      if (s64) b64.in_valid = 1'b0;
      else     b32.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] addi(input logic [11:0] v);
      return {v, 5'd0, 3'b000, 5'd1, 7'h13};
   endfunction

   task automatic rand_stream(input bit s64, input int cnt, input int tbase);
      fork
         begin
            logic [31:0] ins;
            for (int k = 0; k < cnt; k++) begin
               ins = $urandom();
               ins[6:0] = ops[$urandom_range(0, 10)];
               send(s64, ins, 32'(tbase + k));
            end
            stop(s64);
         end
         begin
            for (int k = 0; k < 3 * cnt; k++) begin
               sync();
               if (s64) b64.out_ready = 1'($urandom_range(0, 1));
               else     b32.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      if (s64) b64.out_ready = 1'b1;
      else     b32.out_ready = 1'b1;
      repeat (4) sync();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush32 = 1'b0; flush64 = 1'b0;
      b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b0;
      b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
      chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
      chk("rst_imm", 64'(b32.out_imm), 64'd0);
      chk("rst_fmt", 64'(b32.out_fmt), 64'd0);
      chk("rst_instr", 64'(b32.out_instr), 64'd0);
      chk("rst_tag", 64'(b32.out_tag), 64'd0);
      chk("rst64_out_valid", 64'(b64.out_valid), 64'd0);
      sync();
      rst = 1'b0;

      b32.out_ready = 1'b1;
      send(1'b0, 32'hFFF00093, 32'd10); stop(1'b0);
      @(negedge clk);
      chk("addi_valid", 64'(b32.out_valid), 64'd1);
      chk("addi_imm", 64'(b32.out_imm), 64'hFFFF_FFFF);
      chk("addi_fmt", 64'(b32.out_fmt), 64'd1);
      sync(); send(1'b0, 32'h4040D093, 32'd11); stop(1'b0);
      @(negedge clk);
      chk("srai_imm", 64'(b32.out_imm), 64'h4);
      chk("srai_fmt", 64'(b32.out_fmt), 64'd6);
      sync(); send(1'b0, 32'hFE000EE3, 32'd12); stop(1'b0);
      @(negedge clk);
      chk("beq_imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
      chk("beq_fmt", 64'(b32.out_fmt), 64'd3);
      sync(); send(1'b0, 32'h3002D073, 32'd13); stop(1'b0);
      @(negedge clk);
      chk("csr_imm", 64'(b32.out_imm), 64'h5);
      chk("csr_fmt", 64'(b32.out_fmt), 64'd7);
      repeat (2) sync();

      // Back-to-back offers against a stalled output.
      b32.out_ready = 1'b0;
      b32.in_valid = 1'b1; b32.in_instr = addi(12'd1); b32.in_tag = 32'd1;
      @(negedge clk); chk("bp_rdy1", 64'(b32.in_ready), 64'd1);
      sync(); b32.in_instr = addi(12'd2); b32.in_tag = 32'd2;
      @(negedge clk); chk("bp_rdy2", 64'(b32.in_ready), 64'd1);
      chk("bp_tag_a", 64'(b32.out_tag), 64'd1);
      sync(); b32.in_instr = addi(12'd3); b32.in_tag = 32'd3;
      @(negedge clk); chk("bp_rdy3", 64'(b32.in_ready), 64'd0);
      repeat (3) begin
         sync(); @(negedge clk);
         chk("bp_hold_rdy", 64'(b32.in_ready), 64'd0);
         chk("bp_hold_tag", 64'(b32.out_tag), 64'd1);
         chk("bp_hold_imm", 64'(b32.out_imm), 64'd1);
      end
      sync(); b32.out_ready = 1'b1;
      @(negedge clk); chk("bp_rel_tag1", 64'(b32.out_tag), 64'd1);
      sync(); @(negedge clk);
      chk("bp_rel_tag2", 64'(b32.out_tag), 64'd2);
      chk("bp_rel_rdy", 64'(b32.in_ready), 64'd1);
      sync(); stop(1'b0);
      @(negedge clk); chk("bp_rel_tag3", 64'(b32.out_tag), 64'd3);
      sync(); @(negedge clk); chk("bp_empty", 64'(b32.out_valid), 64'd0);

      // Flush with output and skid both occupied.
      sync(); b32.out_ready = 1'b0;
      send(1'b0, addi(12'd4), 32'd4);
      send(1'b0, addi(12'd5), 32'd5);
      b32.in_instr = addi(12'd6); b32.in_tag = 32'd6; flush32 = 1'b1;
      sync(); flush32 = 1'b0; stop(1'b0);
      @(negedge clk);
      chk("flA_valid", 64'(b32.out_valid), 64'd0);
      chk("flA_rdy", 64'(b32.in_ready), 64'd1);
      b32.out_ready = 1'b1;
      repeat (3) begin sync(); @(negedge clk); chk("flA_quiet", 64'(b32.out_valid), 64'd0); end

      // Flush while an input actually fires.
      sync(); b32.out_ready = 1'b0;
      send(1'b0, addi(12'd8), 32'd8);
      b32.in_instr = addi(12'd9); b32.in_tag = 32'd9; flush32 = 1'b1;
      sync(); flush32 = 1'b0; stop(1'b0);
      @(negedge clk);
      chk("flB_valid", 64'(b32.out_valid), 64'd0);
      chk("flB_rdy", 64'(b32.in_ready), 64'd1);
      b32.out_ready = 1'b1;
      repeat (3) begin sync(); @(negedge clk); chk("flB_quiet", 64'(b32.out_valid), 64'd0); end

      sync();
      rand_stream(1'b0, 60, 100);

      b64.out_ready = 1'b1;
      send(1'b1, 32'h800000B7, 32'd20); stop(1'b1);
      @(negedge clk);
      chk("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
      chk("lui64_fmt", 64'(b64.out_fmt), 64'd5);
      sync(); send(1'b1, 32'h03F0D093, 32'd21); stop(1'b1);
      @(negedge clk);
      chk("srli64_imm", b64.out_imm, 64'd63);
      chk("srli64_fmt", 64'(b64.out_fmt), 64'd6);
      sync();
      rand_stream(1'b1, 40, 300);

      // Reset in the middle of a stalled transfer.
      b64.out_ready = 1'b0;
      send(1'b1, 32'h00500093, 32'd201);
      send(1'b1, 32'h00600093, 32'd202);
      stop(1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(b64.out_valid), 64'd0);
      chk("arst_rdy", 64'(b64.in_ready), 64'd1);
      chk("arst_tag", 64'(b64.out_tag), 64'd0);
      q32.delete(); q64.delete();
      sync(); rst = 1'b0;
      b64.out_ready = 1'b1;
      sync(); send(1'b1, 32'hFFF00093, 32'd203); stop(1'b1);
      @(negedge clk);
      chk("post_rst_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

      b32.out_ready = 1'b1;
      b64.out_ready = 1'b1;
      repeat (20) sync();
      chk("drain32", 64'(q32.size()), 64'd0);
      chk("drain64", 64'(q64.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
